// File: rtl/stack_pkg.sv
// Shared types and sizing for the circular-stack bus initiator.
// Op and state encodings are visible on the stack bus and in the FSM.
package stack_pkg;

  localparam int STACK_DEPTH = 5;
  localparam int STACK_W     = 4;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    PUSH = 2'b01,
    POP  = 2'b10,
    GET  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_e;

endpackage

// File: rtl/stack_occupancy.sv
// Saturating occupancy counter with full/empty/index-valid flags.
// Only built when STACK_MASTER_CHECK_EN is defined.
module stack_occupancy
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic [2:0] idx,
  output logic       full,
  output logic       empty,
  output logic       idx_ok
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (CW > 3) ? CW : 3;

  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_w, cnt_w;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign idx_w = IW'(idx);
  assign cnt_w = IW'(count_q);

  // An index must address an occupied slot and a physical slot.
  assign idx_ok = (idx_w < cnt_w) && (idx_w < IW'(DEPTH));

  always_comb begin
    count_d = count_q;
    if (inc && !full) begin
      count_d = count_q + 1'b1;
    end else if (dec && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stack_master.sv
// Host-side initiator for the circular stack: sequences push/pop/get onto command/index/io_data.
// Define STACK_MASTER_CHECK_EN to add occupancy tracking with overflow/underflow/index errors.
module stack_master
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int W     = STACK_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  input  logic [2:0]   req_index,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic [1:0]   command,
  output logic [2:0]   index,
  inout  wire  [W-1:0] io_data
);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  op_e          command_q, command_d;
  logic [2:0]   index_q, index_d;
  logic         drive_q, drive_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  op_e  req_op_e;
  logic accept;
  logic reject;
  logic acc_err;

  assign req_op_e  = op_e'(req_op);
  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

`ifdef STACK_MASTER_CHECK_EN
  logic occ_full, occ_empty, occ_idx_ok;
  logic occ_inc, occ_dec;

  assign occ_inc = accept && (req_op_e == PUSH);
  assign occ_dec = accept && (req_op_e == POP) && !occ_empty;

  stack_occupancy #(
    .DEPTH(DEPTH)
  ) u_occ (
    .clk   (clk),
    .rst   (reset),
    .inc   (occ_inc),
    .dec   (occ_dec),
    .idx   (req_index),
    .full  (occ_full),
    .empty (occ_empty),
    .idx_ok(occ_idx_ok)
  );

  // Overflowing pushes are still issued; the stack overwrites its oldest entry.
  assign reject  = ((req_op_e == POP) && occ_empty) || ((req_op_e == GET) && !occ_idx_ok);
  assign acc_err = reject || ((req_op_e == PUSH) && occ_full);
`else
  assign reject  = 1'b0;
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    command_d  = command_q;
    index_d    = index_q;
    drive_d    = drive_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = req_op_e;
          wdata_d    = req_data;
          rsp_data_d = '0;
          rsp_err_d  = acc_err;
          if ((req_op_e == NOP) || reject) begin
            state_d = DONE;
          end else begin
            command_d = req_op_e;
            index_d   = (req_op_e == GET) ? req_index : 3'd0;
            drive_d   = (req_op_e == PUSH);
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        command_d = NOP;
        index_d   = 3'd0;
        drive_d   = 1'b0;
        state_d   = (op_q == PUSH) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        rsp_data_d = io_data;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= NOP;
      command_q  <= NOP;
      index_q    <= 3'd0;
      drive_q    <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      command_q  <= command_d;
      index_q    <= index_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign command   = command_q;
  assign index     = index_q;
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // Bus is driven only while the push command is on the wire.
  assign io_data = drive_q ? wdata_q : {W{1'bz}};

endmodule

// File: tb/tb_stack_master.sv
// Directed bench for stack_master with a behavioural circular stack on the shared bus.
// Expectations follow STACK_MASTER_CHECK_EN so either build can be exercised.
module tb_stack_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_data;
  logic [2:0] req_index;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [1:0] command;
  logic [2:0] index;
  wire  [3:0] io_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] BUS_IDLE = 4'hF;

  always #5 clk = ~clk;

  // Released bus floats high so a stray driver is visible.
  pullup (io_data[0]);
  pullup (io_data[1]);
  pullup (io_data[2]);
  pullup (io_data[3]);

  stack_master dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .req_index(req_index),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .command  (command),
    .index    (index),
    .io_data  (io_data)
  );

  // Behavioural 5-entry circular stack; it keeps driving read data until a push.
  logic [3:0] mem [5];
  int         sp;
  logic       stk_en;
  logic [3:0] stk_val;
  bit         mem_init;

  assign io_data = (stk_en && command != 2'b01) ? stk_val : 4'bzzzz;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp     <= 0;
      stk_en <= 1'b0;
      if (!mem_init) begin
        for (int i = 0; i < 5; i++) mem[i] <= 4'(12 + i);
        mem_init <= 1'b1;
      end
    end else begin
      case (command)
        2'b01: begin
          sp                <= (sp + 1) % 5;
          mem[(sp + 1) % 5] <= io_data;
          stk_en            <= 1'b0;
        end
        2'b10: begin
          stk_val <= mem[sp];
          sp      <= (sp + 4) % 5;
          stk_en  <= 1'b1;
        end
        2'b11: begin
          stk_val <= mem[(sp + 5 - int'(index)) % 5];
          stk_en  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Present a request at a negedge; return at the negedge after the handshake edge.
  task automatic send(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    req_index = idx;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 4'h0;
    req_index = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 4'h0; req_index = 3'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
    n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL reset_command: got %b expected 00", command); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (io_data !== BUS_IDLE) begin n_fail++; $display("FAIL reset_bus: got %h expected released (%h)", io_data, BUS_IDLE); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", req_ready); end
    n_checks++; if (rsp_data !== 4'h0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got data %h err %b expected 0/0", rsp_data, rsp_err); end
    @(negedge clk);
  endtask

  task automatic test_push(input logic [3:0] val, input logic exp_err);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL push_ready %h: got %b expected 1", val, req_ready); end
    send(2'b01, val, 3'd0);
    n_checks++; if (command !== 2'b01) begin n_fail++; $display("FAIL push_cmd %h: got %b expected 01", val, command); end
    n_checks++; if (io_data !== val) begin n_fail++; $display("FAIL push_bus %h: got %h expected %h", val, io_data, val); end
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL push_e0 %h: got valid %b ready %b expected 0/0", val, rsp_valid, req_ready); end
    @(negedge clk);
    n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL push_cmd_clr %h: got %b expected 00", val, command); end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL push_rsp_valid %h: got %b expected 1", val, rsp_valid); end
    n_checks++; if (rsp_err !== exp_err || rsp_data !== 4'h0) begin n_fail++; $display("FAIL push_rsp %h: got err %b data %h expected %b/0", val, rsp_err, rsp_data, exp_err); end
    n_checks++; if (io_data !== BUS_IDLE) begin n_fail++; $display("FAIL push_bus_rel %h: got %h expected %h", val, io_data, BUS_IDLE); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL push_end %h: got valid %b ready %b expected 0/1", val, rsp_valid, req_ready); end
  endtask

  task automatic test_read(input logic [1:0] op, input logic [2:0] idx, input logic [3:0] exp);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL read_ready op%b: got %b expected 1", op, req_ready); end
    send(op, 4'h0, idx);
    n_checks++; if (command !== op) begin n_fail++; $display("FAIL read_cmd op%b: got %b expected %b", op, command, op); end
    if (op == 2'b11) begin
      n_checks++; if (index !== idx) begin n_fail++; $display("FAIL read_index: got %0d expected %0d", index, idx); end
    end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_e0_valid op%b: got %b expected 0", op, rsp_valid); end
    @(negedge clk);
    n_checks++; if (command !== 2'b00 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_e1 op%b: got cmd %b valid %b expected 00/0", op, command, rsp_valid); end
    n_checks++; if (io_data !== exp) begin n_fail++; $display("FAIL read_bus op%b: got %h expected %h", op, io_data, exp); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL read_rsp_valid op%b: got %b expected 1", op, rsp_valid); end
    n_checks++; if (rsp_data !== exp || rsp_err !== 1'b0) begin n_fail++; $display("FAIL read_rsp op%b idx%0d: got data %h err %b expected %h/0", op, idx, rsp_data, rsp_err, exp); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL read_end op%b: got valid %b ready %b expected 0/1", op, rsp_valid, req_ready); end
  endtask

  task automatic test_reject(input logic [1:0] op, input logic [2:0] idx, input logic exp_err);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rej_ready op%b: got %b expected 1", op, req_ready); end
    send(op, 4'h0, idx);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rej_valid op%b: got %b expected 1", op, rsp_valid); end
    n_checks++; if (rsp_err !== exp_err || rsp_data !== 4'h0) begin n_fail++; $display("FAIL rej_rsp op%b idx%0d: got err %b data %h expected %b/0", op, idx, rsp_err, rsp_data, exp_err); end
    n_checks++; if (command !== 2'b00) begin n_fail++; $display("FAIL rej_cmd op%b: got %b expected 00", op, command); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || command !== 2'b00) begin n_fail++; $display("FAIL rej_end op%b: got valid %b ready %b cmd %b expected 0/1/00", op, rsp_valid, req_ready, command); end
  endtask

  task automatic test_reset_mid();
    test_push(4'h5, 1'b0);
    send(2'b10, 4'h0, 3'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || command !== 2'b00) begin n_fail++; $display("FAIL mid_rst_out: got valid %b cmd %b expected 0/00", rsp_valid, command); end
    n_checks++; if (io_data !== BUS_IDLE) begin n_fail++; $display("FAIL mid_rst_bus: got %h expected %h", io_data, BUS_IDLE); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", req_ready); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hold: got valid %b ready %b expected 0/0", rsp_valid, req_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_release: got %b expected 1", req_ready); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_rsp: got valid %b err %b expected 0/0", rsp_valid, rsp_err); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reject(2'b00, 3'd0, 1'b0);
    test_push(4'h3, 1'b0);
    test_push(4'h7, 1'b0);
    test_push(4'h9, 1'b0);
    test_read(2'b10, 3'd0, 4'h9);
    test_read(2'b11, 3'd1, 4'h3);
`ifdef STACK_MASTER_CHECK_EN
    test_reject(2'b11, 3'd2, 1'b1);
    test_read(2'b11, 3'd0, 4'h7);
    test_reject(2'b11, 3'd5, 1'b1);
    test_read(2'b10, 3'd0, 4'h7);
    test_read(2'b10, 3'd0, 4'h3);
    test_reject(2'b10, 3'd0, 1'b1);
    test_push(4'h1, 1'b0);
    test_push(4'h2, 1'b0);
    test_push(4'h4, 1'b0);
    test_push(4'h5, 1'b0);
    test_push(4'h6, 1'b0);
    test_push(4'hA, 1'b1);
    test_read(2'b11, 3'd4, 4'h2);
    test_read(2'b10, 3'd0, 4'hA);
    test_read(2'b10, 3'd0, 4'h6);
    test_read(2'b10, 3'd0, 4'h5);
    test_read(2'b10, 3'd0, 4'h4);
    test_read(2'b10, 3'd0, 4'h2);
    test_reject(2'b10, 3'd0, 1'b1);
    test_reset_mid();
    test_reject(2'b10, 3'd0, 1'b1);
`else
    test_read(2'b11, 3'd2, 4'hC);
    test_reset_mid();
    test_read(2'b10, 3'd0, 4'hC);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
